// File: rtl/axi_lite_sig_host_pkg.sv
// Shared definitions for the signature-chip AXI4-Lite host:
// register offsets, STATUS bit positions, op encodings,
// response codes, and the command / transfer-engine state types.
package axi_lite_sig_host_pkg;

  localparam logic [3:0] REG_CTRL     = 4'h0;
  localparam logic [3:0] REG_STATUS   = 4'h4;
  localparam logic [3:0] REG_DATA_IN  = 4'h8;
  localparam logic [3:0] REG_DATA_OUT = 4'hC;

  localparam int unsigned STAT_BUSY   = 0;
  localparam int unsigned STAT_DONE   = 1;
  localparam int unsigned STAT_ERROR  = 2;
  localparam int unsigned STAT_VERIFY = 3;

  localparam logic [1:0] OP_SIGN   = 2'b00;
  localparam logic [1:0] OP_VERIFY = 2'b01;

  localparam logic [1:0] RSP_OK      = 2'b00;
  localparam logic [1:0] RSP_SLVERR  = 2'b01;
  localparam logic [1:0] RSP_DEVERR  = 2'b10;
  localparam logic [1:0] RSP_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_MSG,
    ST_WR_CTRL,
    ST_RD_STAT,
    ST_RD_SIG,
    ST_RESP
  } state_t;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_AW_W,
    PH_B,
    PH_AR,
    PH_R
  } xfer_phase_t;

endpackage

// File: rtl/axi_lite_master_xfer.sv
// Single-beat AXI4-Lite master engine. One transfer outstanding at a time.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   i_req/i_wr/i_addr/i_wdata  transfer request, held by the requester until o_done
//   o_done/o_resp/o_rdata      completion strobe (B or R handshake cycle) and result
//   o_aw*/o_w*/i_b*/o_ar*/i_r* AXI4-Lite master channels
module axi_lite_master_xfer
  import axi_lite_sig_host_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [3:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_done,
  output logic [1:0]  o_resp,
  output logic [31:0] o_rdata,
  output logic        o_awvalid,
  input  logic        i_awready,
  output logic [3:0]  o_awaddr,
  output logic        o_wvalid,
  input  logic        i_wready,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  input  logic        i_bvalid,
  output logic        o_bready,
  input  logic [1:0]  i_bresp,
  output logic        o_arvalid,
  input  logic        i_arready,
  output logic [3:0]  o_araddr,
  input  logic        i_rvalid,
  output logic        o_rready,
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_rresp
);

  xfer_phase_t r_phase, w_phase_next;
  logic        r_aw_ok, r_w_ok;

  assign o_awaddr = i_addr;
  assign o_araddr = i_addr;
  assign o_wdata  = i_wdata;
  assign o_wstrb  = 4'hF;
  assign o_rdata  = i_rdata;

  // The request is launched combinationally from IDLE so a new transfer can
  // start the cycle after the previous B/R handshake.
  always_comb begin
    w_phase_next = r_phase;
    o_awvalid    = 1'b0;
    o_wvalid     = 1'b0;
    o_bready     = 1'b0;
    o_arvalid    = 1'b0;
    o_rready     = 1'b0;
    o_done       = 1'b0;
    o_resp       = 2'b00;
    case (r_phase)
      PH_IDLE: begin
        if (i_req) begin
          if (i_wr) begin
            o_awvalid    = 1'b1;
            o_wvalid     = 1'b1;
            w_phase_next = (i_awready && i_wready) ? PH_B : PH_AW_W;
          end else begin
            o_arvalid    = 1'b1;
            w_phase_next = i_arready ? PH_R : PH_AR;
          end
        end
      end
      PH_AW_W: begin
        o_awvalid = !r_aw_ok;
        o_wvalid  = !r_w_ok;
        if ((r_aw_ok || i_awready) && (r_w_ok || i_wready)) w_phase_next = PH_B;
      end
      PH_B: begin
        o_bready = 1'b1;
        if (i_bvalid) begin
          o_done       = 1'b1;
          o_resp       = i_bresp;
          w_phase_next = PH_IDLE;
        end
      end
      PH_AR: begin
        o_arvalid = 1'b1;
        if (i_arready) w_phase_next = PH_R;
      end
      PH_R: begin
        o_rready = 1'b1;
        if (i_rvalid) begin
          o_done       = 1'b1;
          o_resp       = i_rresp;
          w_phase_next = PH_IDLE;
        end
      end
      default: w_phase_next = PH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= PH_IDLE;
      r_aw_ok <= 1'b0;
      r_w_ok  <= 1'b0;
    end else begin
      r_phase <= w_phase_next;
      // Handshake flags accumulate only while both channels are still open.
      r_aw_ok <= ((r_phase == PH_AW_W) && r_aw_ok) || (o_awvalid && i_awready);
      r_w_ok  <= ((r_phase == PH_AW_W) && r_w_ok)  || (o_wvalid && i_wready);
    end
  end

endmodule

// File: rtl/axi_lite_sig_host.sv
// Host-side AXI4-Lite master for the signature chip. Per command: writes the
// message to DATA_IN, starts the op via CTRL, polls STATUS, reads the signature
// from DATA_OUT (sign ops), then returns one response beat.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   cmd_valid/cmd_ready/cmd_op/cmd_msg   command request (accepted only in IDLE)
//   rsp_valid/rsp_ready/rsp_status/rsp_sig/rsp_verified   response beat
//   m_axi_*                         AXI4-Lite master to the chip's slave port
module axi_lite_sig_host
  import axi_lite_sig_host_pkg::*;
#(
  parameter int unsigned MSG_WORDS    = 8,
  parameter int unsigned SIG_WORDS    = 17,
  parameter int unsigned POLL_TIMEOUT = 65535
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic [MSG_WORDS*32-1:0]      cmd_msg,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [1:0]                   rsp_status,
  output logic [(SIG_WORDS-1)*32+7:0]  rsp_sig,
  output logic                         rsp_verified,
  output logic                         m_axi_awvalid,
  input  logic                         m_axi_awready,
  output logic [3:0]                   m_axi_awaddr,
  output logic                         m_axi_wvalid,
  input  logic                         m_axi_wready,
  output logic [31:0]                  m_axi_wdata,
  output logic [3:0]                   m_axi_wstrb,
  input  logic                         m_axi_bvalid,
  output logic                         m_axi_bready,
  input  logic [1:0]                   m_axi_bresp,
  output logic                         m_axi_arvalid,
  input  logic                         m_axi_arready,
  output logic [3:0]                   m_axi_araddr,
  input  logic                         m_axi_rvalid,
  output logic                         m_axi_rready,
  input  logic [31:0]                  m_axi_rdata,
  input  logic [1:0]                   m_axi_rresp
);

  localparam int unsigned SIG_BITS = (SIG_WORDS - 1) * 32 + 8;
  localparam int unsigned WORD_W   = $clog2((SIG_WORDS > MSG_WORDS) ? SIG_WORDS : MSG_WORDS);
  localparam int unsigned POLL_W   = $clog2(POLL_TIMEOUT + 1);

  state_t                  r_state, w_state_next;
  logic [1:0]              r_op;
  logic [MSG_WORDS*32-1:0] r_msg;
  logic [WORD_W-1:0]       r_word;
  logic [POLL_W-1:0]       r_poll;
  logic [POLL_W-1:0]       w_poll_inc;
  logic [SIG_BITS-1:0]     r_sig;
  logic [1:0]              r_status;
  logic                    r_verified;

  logic        w_req, w_wr, w_done;
  logic [3:0]  w_addr;
  logic [31:0] w_wdata, w_rdata;
  logic [1:0]  w_resp;
  logic        w_resp_err, w_last_msg, w_last_sig;

  assign cmd_ready    = (r_state == ST_IDLE);
  assign rsp_valid    = (r_state == ST_RESP);
  assign rsp_status   = r_status;
  assign rsp_sig      = r_sig;
  assign rsp_verified = r_verified;

  assign w_poll_inc = r_poll + 1'b1;
  assign w_resp_err = (w_resp != 2'b00);
  assign w_last_msg = (r_word == WORD_W'(MSG_WORDS - 1));
  assign w_last_sig = (r_word == WORD_W'(SIG_WORDS - 1));

  axi_lite_master_xfer u_xfer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (w_req),
    .i_wr      (w_wr),
    .i_addr    (w_addr),
    .i_wdata   (w_wdata),
    .o_done    (w_done),
    .o_resp    (w_resp),
    .o_rdata   (w_rdata),
    .o_awvalid (m_axi_awvalid),
    .i_awready (m_axi_awready),
    .o_awaddr  (m_axi_awaddr),
    .o_wvalid  (m_axi_wvalid),
    .i_wready  (m_axi_wready),
    .o_wdata   (m_axi_wdata),
    .o_wstrb   (m_axi_wstrb),
    .i_bvalid  (m_axi_bvalid),
    .o_bready  (m_axi_bready),
    .i_bresp   (m_axi_bresp),
    .o_arvalid (m_axi_arvalid),
    .i_arready (m_axi_arready),
    .o_araddr  (m_axi_araddr),
    .i_rvalid  (m_axi_rvalid),
    .o_rready  (m_axi_rready),
    .i_rdata   (m_axi_rdata),
    .i_rresp   (m_axi_rresp)
  );

  always_comb begin
    w_state_next = r_state;
    w_req        = 1'b0;
    w_wr         = 1'b0;
    w_addr       = REG_CTRL;
    w_wdata      = '0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) w_state_next = cmd_op[1] ? ST_RESP : ST_WR_MSG;
      end
      ST_WR_MSG: begin
        w_req   = 1'b1;
        w_wr    = 1'b1;
        w_addr  = REG_DATA_IN;
        w_wdata = r_msg[31:0];
        if (w_done) begin
          if (w_resp_err)      w_state_next = ST_RESP;
          else if (w_last_msg) w_state_next = ST_WR_CTRL;
        end
      end
      ST_WR_CTRL: begin
        w_req   = 1'b1;
        w_wr    = 1'b1;
        w_addr  = REG_CTRL;
        w_wdata = {29'b0, r_op, 1'b1};
        if (w_done) w_state_next = w_resp_err ? ST_RESP : ST_RD_STAT;
      end
      ST_RD_STAT: begin
        w_req  = 1'b1;
        w_addr = REG_STATUS;
        if (w_done) begin
          if (w_resp_err || w_rdata[STAT_ERROR]) w_state_next = ST_RESP;
          else if (w_rdata[STAT_DONE])
            w_state_next = (r_op == OP_VERIFY) ? ST_RESP : ST_RD_SIG;
          else if (w_poll_inc == POLL_W'(POLL_TIMEOUT)) w_state_next = ST_RESP;
        end
      end
      ST_RD_SIG: begin
        w_req  = 1'b1;
        w_addr = REG_DATA_OUT;
        if (w_done && (w_resp_err || w_last_sig)) w_state_next = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op       <= '0;
      r_msg      <= '0;
      r_word     <= '0;
      r_poll     <= '0;
      r_sig      <= '0;
      r_status   <= RSP_OK;
      r_verified <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_op       <= cmd_op;
            r_msg      <= cmd_msg;
            r_word     <= '0;
            r_poll     <= '0;
            r_sig      <= '0;
            r_verified <= 1'b0;
            r_status   <= cmd_op[1] ? RSP_TIMEOUT : RSP_OK;
          end
        end
        ST_WR_MSG: begin
          if (w_done) begin
            if (w_resp_err) r_status <= RSP_SLVERR;
            else begin
              // Message shifts down so the next word is always in [31:0].
              r_msg  <= r_msg >> 32;
              r_word <= r_word + 1'b1;
            end
          end
        end
        ST_WR_CTRL: begin
          if (w_done) begin
            r_word <= '0;
            if (w_resp_err) r_status <= RSP_SLVERR;
          end
        end
        ST_RD_STAT: begin
          if (w_done) begin
            if (w_resp_err)                r_status <= RSP_SLVERR;
            else if (w_rdata[STAT_ERROR])  r_status <= RSP_DEVERR;
            else if (w_rdata[STAT_DONE])   r_verified <= (r_op == OP_VERIFY) && w_rdata[STAT_VERIFY];
            else begin
              r_poll <= w_poll_inc;
              if (w_poll_inc == POLL_W'(POLL_TIMEOUT)) r_status <= RSP_TIMEOUT;
            end
          end
        end
        ST_RD_SIG: begin
          if (w_done) begin
            if (w_resp_err) r_status <= RSP_SLVERR;
            else begin
              for (int unsigned k = 0; k < SIG_WORDS - 1; k++) begin
                if (r_word == WORD_W'(k)) r_sig[k*32 +: 32] <= w_rdata;
              end
              // Final word carries only 8 signature bits.
              if (w_last_sig) r_sig[SIG_BITS-1 -: 8] <= w_rdata[7:0];
              r_word <= r_word + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_sig_host.sv
module tb_axi_lite_sig_host;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid, cmd_ready;
  logic [1:0]   cmd_op;
  logic [255:0] cmd_msg;
  logic         rsp_valid, rsp_ready;
  logic [1:0]   rsp_status;
  logic [519:0] rsp_sig;
  logic         rsp_verified;
  logic         m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [3:0]   m_axi_awaddr, m_axi_wstrb, m_axi_araddr;
  logic [31:0]  m_axi_wdata, m_axi_rdata;
  logic         m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic         m_axi_rvalid, m_axi_rready;
  logic [1:0]   m_axi_bresp, m_axi_rresp;

  always #5 clk = ~clk;

  axi_lite_sig_host #(.MSG_WORDS(8), .SIG_WORDS(17), .POLL_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_msg(cmd_msg),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .rsp_sig(rsp_sig), .rsp_verified(rsp_verified),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_bresp(m_axi_bresp), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Slave model configuration (written only by the stimulus process)
  int          aw_delay = 0;
  int          stat_pre_n = 0;
  logic [31:0] stat_pre_val = 32'h1;
  logic [31:0] stat_final_val = 32'h2;
  int          err_word = -1;
  int          stat_base = 0;
  int          out_base = 0;

  // Slave model state and logs (written only by the slave process)
  int          aw_cnt, w_cnt;
  logic        got_aw, got_w;
  logic [3:0]  aw_q;
  logic [31:0] w_q;
  int          n_stat = 0, n_out = 0, n_b = 0, n_aw_hs = 0, n_w_hs = 0;
  logic [3:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int          aw_dur[$];
  int          w_dur[$];

  function automatic logic [31:0] sig_word(input int k);
    return {8'(k), 8'h5A, 8'(255 - k), 8'hC3};
  endfunction

  function automatic logic [519:0] exp_sig(input int nwords);
    logic [519:0] s = '0;
    for (int k = 0; k < nwords && k < 16; k++) s[k*32 +: 32] = sig_word(k);
    if (nwords >= 17) s[519:512] = sig_word(16)[7:0];
    return s;
  endfunction

  assign m_axi_awready = (aw_cnt >= aw_delay);
  assign m_axi_wready  = 1'b1;
  assign m_axi_arready = 1'b1;
  assign m_axi_bresp   = 2'b00;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axi_bvalid <= 1'b0;
      m_axi_rvalid <= 1'b0;
      m_axi_rdata  <= '0;
      m_axi_rresp  <= 2'b00;
      got_aw <= 1'b0;
      got_w  <= 1'b0;
      aw_cnt <= 0;
      w_cnt  <= 0;
      aw_q   <= '0;
      w_q    <= '0;
    end else begin
      if (m_axi_awvalid && m_axi_awready) begin
        got_aw <= 1'b1; aw_q <= m_axi_awaddr; aw_cnt <= 0;
        aw_dur.push_back(aw_cnt + 1); n_aw_hs <= n_aw_hs + 1;
      end else if (m_axi_awvalid) aw_cnt <= aw_cnt + 1;
      if (m_axi_wvalid && m_axi_wready) begin
        got_w <= 1'b1; w_q <= m_axi_wdata; w_cnt <= 0;
        w_dur.push_back(w_cnt + 1); n_w_hs <= n_w_hs + 1;
      end else if (m_axi_wvalid) w_cnt <= w_cnt + 1;
      if ((got_aw || (m_axi_awvalid && m_axi_awready)) &&
          (got_w || (m_axi_wvalid && m_axi_wready)) && !m_axi_bvalid) begin
        m_axi_bvalid <= 1'b1;
        got_aw <= 1'b0;
        got_w  <= 1'b0;
        wr_addr.push_back((m_axi_awvalid && m_axi_awready) ? m_axi_awaddr : aw_q);
        wr_data.push_back((m_axi_wvalid && m_axi_wready) ? m_axi_wdata : w_q);
      end
      if (m_axi_bvalid && m_axi_bready) begin
        m_axi_bvalid <= 1'b0; n_b <= n_b + 1;
      end
      if (m_axi_arvalid && m_axi_arready) begin
        m_axi_rvalid <= 1'b1;
        m_axi_rresp  <= 2'b00;
        m_axi_rdata  <= '0;
        if (m_axi_araddr == 4'h4) begin
          m_axi_rdata <= ((n_stat - stat_base) < stat_pre_n) ? stat_pre_val : stat_final_val;
          n_stat <= n_stat + 1;
        end else if (m_axi_araddr == 4'hC) begin
          m_axi_rdata <= sig_word(n_out - out_base);
          m_axi_rresp <= ((n_out - out_base) == err_word) ? 2'b10 : 2'b00;
          n_out <= n_out + 1;
        end
      end
      if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [519:0] obs, input logic [519:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue a command and wait (bounded) for the response beat; lat counts rising
  // edges after the accepting edge until rsp_valid is seen.
  task automatic run_cmd(input logic [1:0] op, input logic [255:0] msg, output int lat);
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1'b1);
    stat_base = n_stat;
    out_base  = n_out;
    cmd_op    = op;
    cmd_msg   = msg;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 5000) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("rsp_valid_wait", rsp_valid, 1'b1);
  endtask

  task automatic finish_rsp(input int hold);
    logic [1:0]   st  = rsp_status;
    logic [519:0] sg  = rsp_sig;
    repeat (hold) begin
      @(posedge clk);
      #1;
      chk("rsp_hold_valid", rsp_valid, 1'b1);
      chk("rsp_hold_status", rsp_status, st);
      chk("rsp_hold_sig", rsp_sig, sg);
    end
    @(negedge clk) rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    chk("rsp_drop", rsp_valid, 1'b0);
    chk("cmd_ready_back", cmd_ready, 1'b1);
  endtask

  localparam logic [255:0] MSG =
    256'h0102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f20;
  logic [31:0] exp_msg [8] = '{32'h1d1e1f20, 32'h191a1b1c, 32'h15161718, 32'h11121314,
                              32'h0d0e0f10, 32'h090a0b0c, 32'h05060708, 32'h01020304};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, wb, ab, bb, awb, wdb;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_msg = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_awvalid", m_axi_awvalid, 1'b0);
    chk("rst_wvalid", m_axi_wvalid, 1'b0);
    chk("rst_arvalid", m_axi_arvalid, 1'b0);
    chk("rst_bready", m_axi_bready, 1'b0);
    chk("rst_rready", m_axi_rready, 1'b0);
    chk("rst_rsp_status", rsp_status, 2'b00);
    chk("rst_rsp_sig", rsp_sig, '0);
    @(negedge clk) rst_n = 1'b1;

    // Sign, zero-wait slave, done on first poll
    stat_pre_n = 0; stat_final_val = 32'h2;
    wb = wr_data.size();
    run_cmd(2'b00, MSG, lat);
    chk("sign_latency", lat, 54);
    chk("sign_nwrites", wr_data.size() - wb, 9);
    for (int k = 0; k < 8; k++) begin
      chk("sign_msg_addr", wr_addr[wb + k], 4'h8);
      chk("sign_msg_data", wr_data[wb + k], exp_msg[k]);
    end
    chk("sign_ctrl_addr", wr_addr[wb + 8], 4'h0);
    chk("sign_ctrl_data", wr_data[wb + 8], 32'h1);
    chk("sign_polls", n_stat - stat_base, 1);
    chk("sign_sig_reads", n_out - out_base, 17);
    chk("sign_status", rsp_status, 2'b00);
    chk("sign_sig", rsp_sig, exp_sig(17));
    chk("sign_verified", rsp_verified, 1'b0);
    finish_rsp(3);

    // awready delayed 3 cycles, wready immediate
    aw_delay = 3;
    wb = wr_data.size(); ab = aw_dur.size(); awb = n_aw_hs; wdb = n_w_hs; bb = n_b;
    run_cmd(2'b00, MSG, lat);
    chk("dly_aw_cycles", aw_dur[ab], 4);
    chk("dly_w_cycles", w_dur[ab], 1);
    chk("dly_aw_hs", n_aw_hs - awb, 9);
    chk("dly_w_hs", n_w_hs - wdb, 9);
    chk("dly_b_count", n_b - bb, 9);
    chk("dly_data0", wr_data[wb], exp_msg[0]);
    chk("dly_data7", wr_data[wb + 7], exp_msg[7]);
    chk("dly_status", rsp_status, 2'b00);
    chk("dly_sig", rsp_sig, exp_sig(17));
    finish_rsp(0);
    aw_delay = 0;

    // Verify: five busy polls then done+verify_valid
    stat_pre_n = 5; stat_pre_val = 32'h1; stat_final_val = 32'hA;
    wb = wr_data.size();
    run_cmd(2'b01, MSG, lat);
    chk("ver_polls", n_stat - stat_base, 6);
    chk("ver_sig_reads", n_out - out_base, 0);
    chk("ver_ctrl_data", wr_data[wb + 8], 32'h3);
    chk("ver_verified", rsp_verified, 1'b1);
    chk("ver_status", rsp_status, 2'b00);
    finish_rsp(0);

    // Timeout: never done
    stat_pre_n = 1000;
    run_cmd(2'b00, MSG, lat);
    chk("tmo_polls", n_stat - stat_base, 16);
    chk("tmo_sig_reads", n_out - out_base, 0);
    chk("tmo_status", rsp_status, 2'b11);
    finish_rsp(0);

    // Device error: error and done both set
    stat_pre_n = 0; stat_final_val = 32'h6;
    run_cmd(2'b00, MSG, lat);
    chk("dev_polls", n_stat - stat_base, 1);
    chk("dev_sig_reads", n_out - out_base, 0);
    chk("dev_status", rsp_status, 2'b10);
    finish_rsp(0);

    // SLVERR on DATA_OUT word 4
    stat_final_val = 32'h2; err_word = 4;
    run_cmd(2'b00, MSG, lat);
    chk("slv_sig_reads", n_out - out_base, 5);
    chk("slv_status", rsp_status, 2'b01);
    chk("slv_sig_partial", rsp_sig, exp_sig(4));
    finish_rsp(0);
    err_word = -1;

    // Bad op: no AXI traffic
    wb = wr_data.size();
    run_cmd(2'b10, MSG, lat);
    chk("bad_writes", wr_data.size() - wb, 0);
    chk("bad_polls", n_stat - stat_base, 0);
    chk("bad_status", rsp_status, 2'b11);
    chk("bad_sig", rsp_sig, '0);
    finish_rsp(0);

    // Reset asserted while awvalid is held in WR_MSG
    aw_delay = 3;
    @(negedge clk);
    cmd_op = 2'b00; cmd_msg = MSG; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_awvalid_pre", m_axi_awvalid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_awvalid", m_axi_awvalid, 1'b0);
    chk("mid_wvalid", m_axi_wvalid, 1'b0);
    chk("mid_arvalid", m_axi_arvalid, 1'b0);
    chk("mid_bready", m_axi_bready, 1'b0);
    chk("mid_cmd_ready", cmd_ready, 1'b1);
    chk("mid_rsp_valid", rsp_valid, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    aw_delay = 0;
    wb = wr_data.size();
    run_cmd(2'b00, MSG, lat);
    chk("post_nwrites", wr_data.size() - wb, 9);
    chk("post_data0", wr_data[wb], exp_msg[0]);
    chk("post_status", rsp_status, 2'b00);
    chk("post_sig", rsp_sig, exp_sig(17));
    finish_rsp(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
